// File: rtl/mips_pkg.sv
// Shared EX-stage definitions for the multiply/divide unit.
// Op encoding, FSM states and iteration count.
package mips_pkg;

    localparam int MD_ITER = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIN  = 2'b10
    } md_state_t;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// EX-stage mul/div bundle: ID/EX operands in, HI/LO and stall out.
// master = pipeline/hazard side, slave = the mul/div unit.
interface ex_muldiv_unit_if
    import mips_pkg::*;
#(
    parameter int WIDTH = MD_ITER
);

    logic             start;
    muldiv_op_t       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             hi_we;
    logic             lo_we;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b,
        output hi_we, lo_we, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b,
        input  hi_we, lo_we, flush,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Shift-add multiply and restoring divide share one accumulator.
module ex_muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = MD_ITER
) (
    input  logic clk,
    input  logic rst_n,
    ex_muldiv_unit_if.slave md
);

    localparam int CW = $clog2(WIDTH);

    md_state_t          state;
    md_state_t          state_nx;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   a_orig;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               dz;

    logic               accept;
    logic               idle_wr;
    logic               sgn_in;
    logic               div_in;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_nx;
    logic [WIDTH:0]     rs;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] div_nx;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   q_s;
    logic [WIDTH-1:0]   r_s;

    assign accept  = (state == IDLE) && md.start && !md.flush;
    assign idle_wr = (state == IDLE) && !md.flush;
    assign sgn_in  = ~md.op[0];
    assign div_in  = md.op[1];
    assign sign_a  = sgn_in & md.src_a[WIDTH-1];
    assign sign_b  = sgn_in & md.src_b[WIDTH-1];
    assign abs_a   = sign_a ? -md.src_a : md.src_a;
    assign abs_b   = sign_b ? -md.src_b : md.src_b;

    // Multiply: {P_hi, P_lo}, multiplier consumed from P_lo LSB-first
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
                   + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_nx  = {mul_sum, acc[WIDTH-1:1]};

    // Divide: {R, Q}; shifted R needs one extra bit for the trial subtract
    assign rs      = acc[2*WIDTH-1:WIDTH-1];
    assign diff    = rs - {1'b0, opnd};
    assign div_nx  = diff[WIDTH]
                   ? {rs[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                   : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    assign prod_s  = neg_q ? -acc : acc;
    assign q_s     = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign r_s     = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept) state_nx = RUN;
            RUN: begin
                if (md.flush)     state_nx = IDLE;
                else if (cnt == '0) state_nx = FIN;
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            a_orig <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
        end else if (accept) begin
            cnt    <= CW'(WIDTH - 1);
            acc    <= {{WIDTH{1'b0}}, div_in ? abs_a : abs_b};
            opnd   <= div_in ? abs_b : abs_a;
            a_orig <= md.src_a;
            is_div <= div_in;
            neg_q  <= sign_a ^ sign_b;
            neg_r  <= sign_a;
            dz     <= (md.src_b == '0);
        end else if (state == RUN && !md.flush) begin
            cnt <= cnt - CW'(1);
            acc <= is_div ? div_nx : mul_nx;
        end
    end

    // A flushed FIN cycle must leave HI/LO untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (state == FIN && !md.flush) begin
            if (!is_div) begin
                {hi_q, lo_q} <= prod_s;
            end else if (dz) begin
                hi_q <= a_orig;
                lo_q <= '1;
            end else begin
                hi_q <= r_s;
                lo_q <= q_s;
            end
        end else if (idle_wr) begin
            if (md.hi_we) hi_q <= md.src_a;
            if (md.lo_we) lo_q <= md.src_a;
        end
    end

    assign md.busy = (state != IDLE);
    assign md.done = (state == FIN);
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit with a HI/LO scoreboard queue.
// Inputs driven and outputs sampled on the falling edge.
module tb_ex_muldiv_unit;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    logic [63:0] sb[$];

    ex_muldiv_unit_if #(.WIDTH(32)) md ();

    ex_muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .md    (md)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full operation; cycle 0 is the negedge where start is raised
    task automatic run_op(input string tag, input muldiv_op_t op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp);
        int bad_b;
        int bad_d;
        logic [63:0] e;
        bad_b = 0;
        bad_d = 0;
        @(negedge clk);
        md.start = 1'b1;
        md.op    = op;
        md.src_a = a;
        md.src_b = b;
        sb.push_back(exp);
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            if (c == 1) md.start = 1'b0;
            if (md.busy !== 1'b1) bad_b++;
            if (md.done !== (c == 33)) bad_d++;
        end
        check({tag, "_busy_run"}, 64'(bad_b), 64'd0);
        check({tag, "_done_c33"}, 64'(bad_d), 64'd0);
        @(negedge clk);
        check({tag, "_busy_c34"}, {62'd0, md.busy, md.done}, 64'd0);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_hilo"}, {md.hi, md.lo}, e);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int bad_b;
        int bad_d;

        md.start = 1'b0;
        md.op    = MD_MULT;
        md.src_a = '0;
        md.src_b = '0;
        md.hi_we = 1'b0;
        md.lo_we = 1'b0;
        md.flush = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy_done", {62'd0, md.busy, md.done}, 64'd0);
        check("rst_hilo", {md.hi, md.lo}, 64'd0);
        rst_n = 1'b1;

        run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               64'hFFFF_FFFE_0000_0001);
        run_op("mult_neg", MD_MULT, -32'sd3, 32'd7,
               64'hFFFF_FFFF_FFFF_FFEB);
        run_op("mult_min", MD_MULT, 32'h8000_0000, 32'h8000_0000,
               64'h4000_0000_0000_0000);
        run_op("div_neg", MD_DIV, -32'sd7, 32'd2,
               64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu_7_2", MD_DIVU, 32'd7, 32'd2,
               64'h0000_0001_0000_0003);
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
               64'h0000_0000_8000_0000);

        for (int i = 0; i < 3; i++) begin
            ra = $urandom;
            rb = $urandom | 32'd1;
            run_op("multu_rnd", MD_MULTU, ra, rb,
                   {32'd0, ra} * {32'd0, rb});
            run_op("divu_rnd", MD_DIVU, ra, rb >> (i * 8),
                   {ra % (rb >> (i * 8)), ra / (rb >> (i * 8))});
        end

        run_op("divu_dz", MD_DIVU, 32'd5, 32'd0,
               64'h0000_0005_FFFF_FFFF);

        // Asynchronous reset in cycle 20 of a DIV
        @(negedge clk);
        md.start = 1'b1;
        md.op    = MD_DIV;
        md.src_a = 32'd1000;
        md.src_b = 32'd3;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) md.start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("arst_busy_done", {62'd0, md.busy, md.done}, 64'd0);
        check("arst_hilo", {md.hi, md.lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", MD_DIVU, 32'd100, 32'd7,
               64'h0000_0002_0000_000E);

        // MTHI/MTLO
        @(negedge clk);
        md.hi_we = 1'b1;
        md.src_a = 32'h1234;
        @(negedge clk);
        md.hi_we = 1'b0;
        md.lo_we = 1'b1;
        md.src_a = 32'h5678;
        check("mthi", {32'd0, md.hi}, 64'h1234);
        @(negedge clk);
        md.lo_we = 1'b0;
        check("mtlo", {32'd0, md.lo}, 64'h5678);

        // MULT with ignored start, ignored MTHI, flush in cycle 10
        bad_b = 0;
        bad_d = 0;
        @(negedge clk);
        md.start = 1'b1;
        md.op    = MD_MULT;
        md.src_a = 32'd3;
        md.src_b = 32'd5;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (md.busy !== 1'b1) bad_b++;
            if (md.done !== 1'b0) bad_d++;
            md.start = (c == 5);
            md.op    = (c == 5) ? MD_DIVU : MD_MULT;
            md.hi_we = (c == 7);
            md.src_a = (c == 7) ? 32'hDEAD : 32'd3;
            md.flush = (c == 10);
        end
        check("fl_busy_run", 64'(bad_b), 64'd0);
        @(negedge clk);
        md.flush = 1'b0;
        check("fl_busy_c11", {62'd0, md.busy, md.done}, 64'd0);
        check("fl_hilo", {md.hi, md.lo}, 64'h0000_1234_0000_5678);
        for (int c = 12; c <= 50; c++) begin
            @(negedge clk);
            if (md.busy !== 1'b0) bad_b++;
            if (md.done !== 1'b0) bad_d++;
        end
        check("fl_no_done", 64'(bad_d), 64'd0);
        check("fl_stay_idle", 64'(bad_b), 64'd0);
        check("fl_hilo_kept", {md.hi, md.lo}, 64'h0000_1234_0000_5678);

        // Flush in IDLE blocks start and MTLO
        @(negedge clk);
        md.start = 1'b1;
        md.flush = 1'b1;
        md.lo_we = 1'b1;
        md.src_a = 32'h99;
        @(negedge clk);
        md.start = 1'b0;
        md.flush = 1'b0;
        md.lo_we = 1'b0;
        check("idle_fl_busy", {62'd0, md.busy, md.done}, 64'd0);
        check("idle_fl_lo", {32'd0, md.lo}, 64'h5678);

        run_op("final_mult", MD_MULT, 32'd6, -32'sd9,
               64'hFFFF_FFFF_FFFF_FFCA);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative 32-bit multiply/divide unit in the EX stage, consuming the operands and decoded op held in the ID/EX pipeline register (after forwarding). It runs MULT/MULTU/DIV/DIVU over 32 shift iterations and commits the result to the architectural HI/LO registers. It also services MTHI/MTLO writes and drives a busy stall to the hazard unit. MFHI/MFLO read `hi`/`lo` directly.

## Interface
- `WIDTH`, 32, operand/HI/LO width; iteration count equals WIDTH.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  EX holds a mul/div instruction; sampled at posedge.
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `src_a`  in  WIDTH  rs operand (dividend/multiplicand, MTHI/MTLO data).
- `src_b`  in  WIDTH  rt operand (divisor/multiplier).
- `hi_we`  in  1  MTHI: HI <= src_a.
- `lo_we`  in  1  MTLO: LO <= src_a.
- `flush`  in  1  pipeline clear from hazard unit; aborts an operation in flight.
- `busy`  out  1  operation in flight (stall request).
- `done`  out  1  one-cycle pulse, last cycle of an operation.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States: IDLE, RUN, FIN. `busy` = (state != IDLE), combinational from state. `done` = (state == FIN).
- **IDLE, start=1, flush=0:**
  - Capture abs(src_a) and abs(src_b). Signed ops only; unsigned ops take the values as-is.
  - Capture neg_q = sign_a ^ sign_b and neg_r = sign_a (both 0 for unsigned ops).
  - Capture div-by-zero flag dz = (src_b == 0), plus the original src_a.
  - Counter <= WIDTH-1. Go to RUN.
- **RUN, multiply:** shift-add, LSB-first. 2·WIDTH accumulator {P_hi, P_lo}; add multiplicand to P_hi when the current multiplier bit is 1, then shift right with carry.
- **RUN, divide:** restoring division. Shift {R, Q} left by 1; trial subtract divisor from R. If non-negative, keep the difference and set Q[0]=1.
- **RUN, end:** counter decrements each cycle; at counter==0 go to FIN.
- **FIN, multiply:** {HI, LO} <= neg_q ? −product : product. The 64-bit two's complement negation is applied to the unsigned 64-bit product.
- **FIN, divide:** LO <= neg_q ? −Q : Q; HI <= neg_r ? −R : R.
- **FIN, dz=1:** HI <= original src_a, LO <= {WIDTH{1}}. Latency is unchanged.
- **FIN, exit:** go to IDLE.
- Signed 0x80000000 / −1: the abs path yields LO=0x80000000, HI=0. No trap.
- All arithmetic is unsigned on magnitudes; overflow wraps.
- **hi_we/lo_we:**
  - Honoured only in IDLE, at the same edge; write src_a.
  - Ignored when busy; the hazard unit guarantees a stall.
  - If start is also accepted at that edge, the write still lands; FIN later overwrites it.
- **flush:**
  - In RUN or FIN → IDLE at the next edge. HI/LO unchanged; a FIN-cycle commit is suppressed.
  - In IDLE, flush blocks start and blocks hi_we/lo_we.
- **start while busy:** ignored; no queueing.
- **Reset:** state=IDLE, hi=0, lo=0, counter=0, all datapath regs=0. Therefore busy=0 and done=0, immediately and asynchronously.

## Timing
- Cycle 0: start high, sampled at the end of cycle 0.
- Cycles 1–32: RUN, busy=1.
- Cycle 33: FIN, busy=1, done=1.
- Cycle 34: new hi/lo visible; busy=0. A new start may be sampled in cycle 34.
- Back-to-back: start held high through cycle 34 begins a second operation; it finishes with done in cycle 67.
- MTHI/MTLO: value visible in hi/lo the cycle after the write.
- Flush sampled at the end of cycle k (1..33): busy=0 from cycle k+1; done never pulses.
- Reset mid-operation: outputs go to reset values with no clock edge required.

## Structure
- Shared package `mips_pkg`:
  - `muldiv_op_t` enum: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU.
  - `md_state_t` enum: IDLE, RUN, FIN.
  - Constant `MD_ITER = 32`.
- Single module; the multiply and divide datapaths share the accumulator registers, selected by the captured op. No sub-module is warranted.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → done in cycle 33; HI=0xFFFFFFFE, LO=0x00000001 in cycle 34; busy high in cycles 1–33 only.
- MULT −3 × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB; MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0.
- DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7 / 2 → LO=3, HI=1; DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 5 / 0 → HI=5, LO=0xFFFFFFFF after the full 34-cycle latency.
- MTHI 0x1234 then MULT in progress: start asserted in cycle 5 is ignored; flush in cycle 10 → busy=0 in cycle 11, no done, HI=0x1234 retained; hi_we during busy is ignored.
- rst_n low in cycle 20 of a DIV → busy, done, hi and lo all 0 without a clock edge; the next start after release runs a full 34 cycles.
